fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the synchronous instruction memory: owns the program counter and drives the memory's pc, read_en and flush inputs.
- The memory returns the instruction one clock after the address.
- Tracks which PC the registered instruction belongs to, and handles stall, branch/jump redirect, halt/resume and an out-of-range or misaligned fetch fault.
- Sits between the hazard/branch logic (decode/execute) and the instruction memory.

---
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the program counter, drives the instruction memory's
// pc/read_en/flush inputs and tracks which PC the memory output belongs to.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        read_en,
  output logic        flush,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic [1:0]  state
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_fetch_valid;
  logic        r_fault;
  logic [1:0]  r_state;

  logic        w_read_en;
  logic        w_flush;
  logic        w_misaligned;
  logic [1:0]  w_next_state;
  logic [31:0] w_next_pc;

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  // Priority inside RUN: redirect > halt_req > stall > sequential fetch.
  always_comb begin
    w_read_en    = 1'b0;
    w_flush      = 1'b0;
    w_next_state = r_state;
    w_next_pc    = r_pc;
    case (r_state)
      S_BOOT: begin
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          w_flush = 1'b1;
          if (w_misaligned) w_next_state = S_FAULT;
          else              w_next_pc    = redirect_pc;
        end else if (halt_req) begin
          w_flush      = 1'b1;
          w_next_state = S_HALT;
        end else if (stall) begin
          w_read_en = 1'b0;
        end else if (r_pc < ADDR_LIMIT) begin
          w_read_en = 1'b1;
          w_next_pc = r_pc + 32'd4;
        end else begin
          w_flush      = 1'b1;
          w_next_state = S_FAULT;
        end
      end
      S_HALT: begin
        if (redirect) begin
          w_flush = 1'b1;
          if (w_misaligned) w_next_state = S_FAULT;
          else              w_next_pc    = redirect_pc;
        end else if (resume) begin
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_state       <= S_BOOT;
      r_fetch_pc    <= 32'd0;
      r_fetch_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_state <= w_next_state;
      // Fault flag rises together with the FAULT state and stays until reset.
      if (w_next_state == S_FAULT) r_fault <= 1'b1;
      if (w_read_en) begin
        r_fetch_valid <= 1'b1;
        r_fetch_pc    <= r_pc;
      end else if (w_flush) begin
        r_fetch_valid <= 1'b0;
      end
    end
  end

  assign pc          = r_pc;
  assign read_en     = w_read_en;
  assign flush       = w_flush;
  assign fetch_pc    = r_fetch_pc;
  assign fetch_valid = r_fetch_valid;
  assign fetch_fault = r_fault;
  assign state       = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: the driver pushes hand-computed per-cycle output
// snapshots into a queue; a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  localparam int W = 70;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        read_en;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_fault;
  logic [1:0]  state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests  = 0;
  int           failed = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .read_en     (read_en),
    .flush       (flush),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .state       (state)
  );

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {pc, read_en, flush, fetch_pc, fetch_valid, fetch_fault, state};
      tests++;
      if (act_v !== exp_v) begin
        failed++;
        $display("FAIL %s: got pc=%h re=%b fl=%b fpc=%h fv=%b ff=%b st=%0d, expected pc=%h re=%b fl=%b fpc=%h fv=%b ff=%b st=%0d",
                 nm, act_v[69:38], act_v[37], act_v[36], act_v[35:4], act_v[3], act_v[2], act_v[1:0],
                 exp_v[69:38], exp_v[37], exp_v[36], exp_v[35:4], exp_v[3], exp_v[2], exp_v[1:0]);
      end
    end
  end

  // One clock cycle: apply inputs, queue the expected outputs for this cycle.
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic h, input logic rs,
                     input logic [31:0] e_pc, input logic e_re, input logic e_fl,
                     input logic [31:0] e_fpc, input logic e_fv, input logic e_ff,
                     input logic [1:0] e_st, input string nm);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    halt_req    = h;
    resume      = rs;
    exp_q.push_back({e_pc, e_re, e_fl, e_fpc, e_fv, e_ff, e_st});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    halt_req = 1'b0; resume = 1'b0;
    @(posedge clk);
    #1;
    //  rst s rd rpc           h  rs  pc            re fl fpc           fv ff st
    cyc(1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, "reset");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, "c0_boot");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 1, "c1_first_fetch");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h4,        1, 0, 32'h0,        1, 0, 1, "c2_first_valid");
    cyc(0, 1, 0, 32'h0,       0, 0, 32'h8,        0, 0, 32'h4,        1, 0, 1, "c3_stall");
    cyc(0, 1, 0, 32'h0,       0, 0, 32'h8,        0, 0, 32'h4,        1, 0, 1, "c4_stall");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h8,        1, 0, 32'h4,        1, 0, 1, "c5_unstall");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'hC,        1, 0, 32'h8,        1, 0, 1, "seq_c");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h10,       1, 0, 32'hC,        1, 0, 1, "seq_10");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h14,       1, 0, 32'h10,       1, 0, 1, "seq_14");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h18,       1, 0, 32'h14,       1, 0, 1, "seq_18");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h1C,       1, 0, 32'h18,       1, 0, 1, "seq_1c");
    cyc(0, 0, 1, 32'h100,     0, 0, 32'h20,       0, 1, 32'h1C,       1, 0, 1, "redirect_100");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h100,      1, 0, 32'h1C,       0, 0, 1, "redir_bubble");
    cyc(0, 1, 1, 32'h100,     0, 0, 32'h104,      0, 1, 32'h100,      1, 0, 1, "redirect_stall");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h100,      1, 0, 32'h100,      0, 0, 1, "rs_bubble");
    cyc(0, 0, 1, 32'h40,      0, 0, 32'h104,      0, 1, 32'h100,      1, 0, 1, "redirect_40");
    cyc(0, 0, 0, 32'h0,       1, 0, 32'h40,       0, 1, 32'h100,      0, 0, 1, "halt_req");
    cyc(0, 0, 0, 32'h0,       1, 0, 32'h40,       0, 0, 32'h100,      0, 0, 2, "halt_1");
    cyc(0, 0, 1, 32'h80,      0, 0, 32'h40,       0, 1, 32'h100,      0, 0, 2, "halt_redirect");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h80,       0, 0, 32'h100,      0, 0, 2, "halt_3");
    cyc(0, 1, 0, 32'h0,       1, 0, 32'h80,       0, 0, 32'h100,      0, 0, 2, "halt_4");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h80,       0, 0, 32'h100,      0, 0, 2, "halt_5");
    cyc(0, 0, 0, 32'h0,       0, 1, 32'h80,       0, 0, 32'h100,      0, 0, 2, "resume");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h80,       1, 0, 32'h100,      0, 0, 1, "resume_fetch");
    cyc(0, 0, 1, 32'h3FC,     0, 0, 32'h84,       0, 1, 32'h80,       1, 0, 1, "redirect_3fc");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h3FC,      1, 0, 32'h80,       0, 0, 1, "fetch_3fc");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h400,      0, 1, 32'h3FC,      1, 0, 1, "limit_400");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h400,      0, 0, 32'h3FC,      0, 1, 3, "fault_enter");
    cyc(0, 1, 1, 32'h0,       1, 1, 32'h400,      0, 0, 32'h3FC,      0, 1, 3, "fault_ignores");
    cyc(1, 0, 1, 32'h8,       0, 0, 32'h400,      0, 0, 32'h3FC,      0, 1, 3, "fault_rst");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, "boot_after_fault");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 1, "run_again");
    cyc(0, 0, 1, 32'h102,     0, 0, 32'h4,        0, 1, 32'h0,        1, 0, 1, "redirect_102");
    cyc(1, 0, 0, 32'h0,       0, 0, 32'h4,        0, 0, 32'h0,        0, 1, 3, "misalign_fault");
    cyc(0, 1, 1, 32'h200,     1, 1, 32'h0,        0, 0, 32'h0,        0, 0, 0, "boot_ignores");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 1, "run_3");
    cyc(1, 0, 1, 32'h200,     0, 0, 32'h4,        0, 1, 32'h0,        1, 0, 1, "rst_redirect");
    cyc(0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, "boot_after_rst");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
